// File: rtl/mac_feed_sequencer.sv
// mac_feed_sequencer: feeds weight beats and IFM rows, set by set, into the pre-processing unit.
// Optional feature: define MAC_FEED_ZERO_PAD_EN to zero IFM elements whose elem_valid bit is 0.
module mac_feed_sequencer #(
    parameter int N_ELEM = 64,
    parameter int W_DATA = 9
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [7:0]                 i_cmd_num_sets,
    input  logic [6:0]                 i_cmd_ifm_rows,
    input  logic                       i_src_wfm_valid,
    output logic                       o_src_wfm_ready,
    input  logic [N_ELEM*W_DATA-1:0]   i_src_wfm_data,
    input  logic                       i_src_ifm_valid,
    output logic                       o_src_ifm_ready,
    input  logic [N_ELEM*W_DATA-1:0]   i_src_ifm_data,
    input  logic [N_ELEM-1:0]          i_src_ifm_elem_valid,
    output logic                       o_wfm_valid,
    input  logic                       i_wfm_ready,
    output logic [N_ELEM*W_DATA-1:0]   o_wfm_data,
    output logic                       o_wfm_is_last,
    output logic                       o_ifm_valid,
    input  logic                       i_ifm_ready,
    output logic [N_ELEM*W_DATA-1:0]   o_ifm_data,
    output logic [N_ELEM-1:0]          o_ifm_elem_valid,
    output logic                       o_ifm_inter_end,
    output logic                       o_ifm_accum_end,
    output logic                       o_done,
    input  logic                       i_done_ready
);
    localparam int DW = N_ELEM * W_DATA;
    localparam int CW = ($clog2(N_ELEM) > 7) ? $clog2(N_ELEM) : 7;
    localparam logic [CW-1:0] W_LAST = CW'(N_ELEM - 1);
`ifdef MAC_FEED_ZERO_PAD_EN
    localparam bit ZPAD = 1'b1;
`else
    localparam bit ZPAD = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WFM, IFM, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] beat_cnt, beat_nxt;
    logic [7:0]    set_cnt, set_nxt;
    logic [7:0]    num_sets;
    logic [6:0]    ifm_rows;
    logic          tail, tail_nxt;
    logic          cmd_fire, wfm_fire, ifm_fire;
    logic          w_last, i_last, set_last;
    logic [DW-1:0] ifm_pad;

    assign o_cmd_ready     = (state == IDLE);
    assign o_done          = (state == DONE);
    assign o_src_wfm_ready = (state == WFM) & (!o_wfm_valid | i_wfm_ready);
    assign o_src_ifm_ready = (state == IFM) & !tail & (!o_ifm_valid | i_ifm_ready);
    assign cmd_fire        = i_cmd_valid & o_cmd_ready;
    assign wfm_fire        = i_src_wfm_valid & o_src_wfm_ready;
    assign ifm_fire        = i_src_ifm_valid & o_src_ifm_ready;
    assign w_last          = (beat_cnt == W_LAST);
    assign i_last          = (beat_cnt == CW'(ifm_rows));
    assign set_last        = (set_cnt == num_sets);

    // Invalid IFM elements are zeroed only in the zero-pad build.
    always_comb begin
        ifm_pad = i_src_ifm_data;
        for (int e = 0; e < N_ELEM; e++) begin
            if (ZPAD && !i_src_ifm_elem_valid[e]) begin
                ifm_pad[e*W_DATA +: W_DATA] = '0;
            end
        end
    end

    // Next state and counters; tail marks the final beat waiting to drain before DONE.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        set_nxt   = set_cnt;
        tail_nxt  = tail;
        unique case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_nxt = WFM;
                    beat_nxt  = '0;
                    set_nxt   = '0;
                    tail_nxt  = 1'b0;
                end
            end
            WFM: begin
                if (wfm_fire) begin
                    if (w_last) begin
                        state_nxt = IFM;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            IFM: begin
                if (tail) begin
                    if (!o_ifm_valid || i_ifm_ready) begin
                        state_nxt = DONE;
                        tail_nxt  = 1'b0;
                    end
                end else if (ifm_fire) begin
                    if (i_last) begin
                        beat_nxt = '0;
                        if (set_last) begin
                            tail_nxt = 1'b1;
                        end else begin
                            state_nxt = WFM;
                            set_nxt   = set_cnt + 8'd1;
                        end
                    end else begin
                        beat_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                if (i_done_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            set_cnt  <= '0;
            tail     <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            set_cnt  <= set_nxt;
            tail     <= tail_nxt;
        end
    end

    // Command capture and the single-stage output registers of both streams.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            num_sets         <= '0;
            ifm_rows         <= '0;
            o_wfm_valid      <= 1'b0;
            o_wfm_data       <= '0;
            o_wfm_is_last    <= 1'b0;
            o_ifm_valid      <= 1'b0;
            o_ifm_data       <= '0;
            o_ifm_elem_valid <= '0;
            o_ifm_inter_end  <= 1'b0;
            o_ifm_accum_end  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                num_sets <= i_cmd_num_sets;
                ifm_rows <= i_cmd_ifm_rows;
            end
            if (wfm_fire) begin
                o_wfm_valid   <= 1'b1;
                o_wfm_data    <= i_src_wfm_data;
                o_wfm_is_last <= w_last;
            end else if (i_wfm_ready) begin
                o_wfm_valid <= 1'b0;
            end
            if (ifm_fire) begin
                o_ifm_valid      <= 1'b1;
                o_ifm_data       <= ifm_pad;
                o_ifm_elem_valid <= i_src_ifm_elem_valid;
                o_ifm_inter_end  <= i_last;
                o_ifm_accum_end  <= set_last;
            end else if (i_ifm_ready) begin
                o_ifm_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_feed_sequencer.sv
// tb_mac_feed_sequencer: randomized source data and stalls checked against a beat-list model.
// Build with MAC_FEED_ZERO_PAD_EN defined to exercise the zero-pad variant.
module tb_mac_feed_sequencer;
    localparam int N_ELEM = 64;
    localparam int W_DATA = 9;
    localparam int DW = N_ELEM * W_DATA;
    localparam int HW = DW + N_ELEM + 8;
`ifdef MAC_FEED_ZERO_PAD_EN
    localparam bit ZPAD = 1'b1;
`else
    localparam bit ZPAD = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } wbeat_t;

    typedef struct {
        logic [DW-1:0]     d;
        logic [N_ELEM-1:0] ev;
        logic              ie;
        logic              ae;
    } ibeat_t;

    logic              i_clk;
    logic              i_reset;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [7:0]        i_cmd_num_sets;
    logic [6:0]        i_cmd_ifm_rows;
    logic              i_src_wfm_valid;
    logic              o_src_wfm_ready;
    logic [DW-1:0]     i_src_wfm_data;
    logic              i_src_ifm_valid;
    logic              o_src_ifm_ready;
    logic [DW-1:0]     i_src_ifm_data;
    logic [N_ELEM-1:0] i_src_ifm_elem_valid;
    logic              o_wfm_valid;
    logic              i_wfm_ready;
    logic [DW-1:0]     o_wfm_data;
    logic              o_wfm_is_last;
    logic              o_ifm_valid;
    logic              i_ifm_ready;
    logic [DW-1:0]     o_ifm_data;
    logic [N_ELEM-1:0] o_ifm_elem_valid;
    logic              o_ifm_inter_end;
    logic              o_ifm_accum_end;
    logic              o_done;
    logic              i_done_ready;

    mac_feed_sequencer #(.N_ELEM(N_ELEM), .W_DATA(W_DATA)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_num_sets(i_cmd_num_sets),
        .i_cmd_ifm_rows(i_cmd_ifm_rows),
        .i_src_wfm_valid(i_src_wfm_valid),
        .o_src_wfm_ready(o_src_wfm_ready),
        .i_src_wfm_data(i_src_wfm_data),
        .i_src_ifm_valid(i_src_ifm_valid),
        .o_src_ifm_ready(o_src_ifm_ready),
        .i_src_ifm_data(i_src_ifm_data),
        .i_src_ifm_elem_valid(i_src_ifm_elem_valid),
        .o_wfm_valid(o_wfm_valid),
        .i_wfm_ready(i_wfm_ready),
        .o_wfm_data(o_wfm_data),
        .o_wfm_is_last(o_wfm_is_last),
        .o_ifm_valid(o_ifm_valid),
        .i_ifm_ready(i_ifm_ready),
        .o_ifm_data(o_ifm_data),
        .o_ifm_elem_valid(o_ifm_elem_valid),
        .o_ifm_inter_end(o_ifm_inter_end),
        .o_ifm_accum_end(o_ifm_accum_end),
        .o_done(o_done),
        .i_done_ready(i_done_ready)
    );

    int checks = 0;
    int errors = 0;
    int stall_pct = 0;
    int wout = 0;
    int iout = 0;

    logic [DW-1:0] wsrc_q[$];
    ibeat_t        isrc_q[$];
    wbeat_t        wexp_q[$];
    ibeat_t        iexp_q[$];

    logic          wh = 1'b0;
    logic          ih = 1'b0;
    logic [HW-1:0] wh_snap;
    logic [HW-1:0] ih_snap;
    logic [DW-1:0] last_ifm_data;

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic logic [DW-1:0] pad(input logic [DW-1:0] d, input logic [N_ELEM-1:0] ev);
        logic [DW-1:0] r;
        r = d;
        for (int e = 0; e < N_ELEM; e++) begin
            if (ZPAD && !ev[e]) r[e*W_DATA +: W_DATA] = '0;
        end
        return r;
    endfunction

    // Expected beat list straight from the command: per set, N_ELEM weights then rows+1 IFM rows.
    task automatic build(input int ns, input int rows, input bit force5);
        logic [DW-1:0]     d;
        logic [N_ELEM-1:0] ev;
        for (int s = 0; s <= ns; s++) begin
            for (int k = 0; k < N_ELEM; k++) begin
                d = rnd_word();
                wsrc_q.push_back(d);
                wexp_q.push_back('{d, (k == N_ELEM - 1)});
            end
            for (int r = 0; r <= rows; r++) begin
                d = rnd_word();
                for (int e = 0; e < N_ELEM; e++) ev[e] = ($urandom_range(0, 3) != 0);
                if (force5 && r == 0) begin
                    ev[5] = 1'b0;
                    d[5*W_DATA +: W_DATA] = 9'h0A5;
                end
                isrc_q.push_back('{d, ev, 1'b0, 1'b0});
                iexp_q.push_back('{pad(d, ev), ev, (r == rows), (s == ns)});
            end
        end
    endtask

    task automatic cycle();
        wbeat_t we;
        ibeat_t ie;
        @(posedge i_clk);
        #1;
        i_wfm_ready     = ($urandom_range(0, 99) >= stall_pct);
        i_ifm_ready     = ($urandom_range(0, 99) >= stall_pct);
        i_src_wfm_valid = (wsrc_q.size() > 0);
        i_src_wfm_data  = (wsrc_q.size() > 0) ? wsrc_q[0] : '0;
        i_src_ifm_valid = (isrc_q.size() > 0);
        i_src_ifm_data  = (isrc_q.size() > 0) ? isrc_q[0].d : '0;
        i_src_ifm_elem_valid = (isrc_q.size() > 0) ? isrc_q[0].ev : '0;
        #1;
        checks++;
        assert (!(o_src_wfm_ready && o_src_ifm_ready)) else begin
            errors++;
            $error("FAIL both_src_ready observed=1 expected=0");
        end
        if (wh) chk("wfm_hold", HW'({o_wfm_valid, o_wfm_is_last, o_wfm_data}), wh_snap);
        if (ih) chk("ifm_hold", HW'({o_ifm_valid, o_ifm_inter_end, o_ifm_accum_end,
                                     o_ifm_elem_valid, o_ifm_data}), ih_snap);
        wh = o_wfm_valid && !i_wfm_ready;
        wh_snap = HW'({o_wfm_valid, o_wfm_is_last, o_wfm_data});
        ih = o_ifm_valid && !i_ifm_ready;
        ih_snap = HW'({o_ifm_valid, o_ifm_inter_end, o_ifm_accum_end, o_ifm_elem_valid, o_ifm_data});
        if (o_wfm_valid && i_wfm_ready) begin
            checks++;
            assert (wexp_q.size() > 0) else begin
                errors++;
                $error("FAIL wfm_extra observed=beat%0d expected=none", wout);
            end
            if (wexp_q.size() > 0) begin
                we = wexp_q.pop_front();
                chk("wfm_data", HW'(o_wfm_data), HW'(we.d));
                chk("wfm_is_last", HW'(o_wfm_is_last), HW'(we.last));
            end
            wout++;
        end
        if (o_ifm_valid && i_ifm_ready) begin
            checks++;
            assert (iexp_q.size() > 0) else begin
                errors++;
                $error("FAIL ifm_extra observed=beat%0d expected=none", iout);
            end
            if (iexp_q.size() > 0) begin
                ie = iexp_q.pop_front();
                chk("ifm_data", HW'(o_ifm_data), HW'(ie.d));
                chk("ifm_elem_valid", HW'(o_ifm_elem_valid), HW'(ie.ev));
                chk("ifm_flags", HW'({o_ifm_inter_end, o_ifm_accum_end}), HW'({ie.ie, ie.ae}));
            end
            last_ifm_data = o_ifm_data;
            iout++;
        end
        if (o_src_wfm_ready && i_src_wfm_valid) void'(wsrc_q.pop_front());
        if (o_src_ifm_ready && i_src_ifm_valid) void'(isrc_q.pop_front());
    endtask

    task automatic issue(input int ns, input int rows);
        wout = 0;
        iout = 0;
        i_cmd_num_sets = 8'(ns);
        i_cmd_ifm_rows = 7'(rows);
        i_cmd_valid = 1'b1;
        chk("cmd_ready_idle", HW'(o_cmd_ready), HW'(1));
        cycle();
        i_cmd_valid = 1'b0;
        i_cmd_num_sets = 8'($urandom);
        i_cmd_ifm_rows = 7'($urandom);
        chk("cmd_ready_busy", HW'(o_cmd_ready), HW'(0));
    endtask

    task automatic run_to_done(input int ns, input int rows, input string tag);
        int n;
        n = 0;
        while (!o_done && n < 4000) begin
            cycle();
            n++;
        end
        checks++;
        assert (o_done) else begin
            errors++;
            $error("FAIL %s_done_timeout observed=%0d expected=1", tag, o_done);
        end
        chk({tag, "_wfm_beats"}, HW'(wout), HW'((ns + 1) * N_ELEM));
        chk({tag, "_ifm_beats"}, HW'(iout), HW'((ns + 1) * (rows + 1)));
        chk({tag, "_ifm_drained"}, HW'(o_ifm_valid), HW'(0));
    endtask

    task automatic release_done();
        i_done_ready = 1'b1;
        cycle();
        chk("done_release", HW'({o_done, o_cmd_ready}), HW'(2'b01));
        i_done_ready = 1'b0;
    endtask

    initial begin
        i_clk = 1'b0;
        i_reset = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_num_sets = '0;
        i_cmd_ifm_rows = '0;
        i_src_wfm_valid = 1'b0;
        i_src_wfm_data = '0;
        i_src_ifm_valid = 1'b0;
        i_src_ifm_data = '0;
        i_src_ifm_elem_valid = '0;
        i_wfm_ready = 1'b0;
        i_ifm_ready = 1'b0;
        i_done_ready = 1'b0;

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_valids", HW'({o_wfm_valid, o_ifm_valid, o_done}), HW'(0));
        chk("rst_flags", HW'({o_wfm_is_last, o_ifm_inter_end, o_ifm_accum_end}), HW'(0));
        chk("rst_wfm_data", HW'(o_wfm_data), HW'(0));
        chk("rst_ifm_data", HW'({o_ifm_elem_valid, o_ifm_data}), HW'(0));
        i_reset = 1'b1;
        #1;
        chk("rst_cmd_ready", HW'(o_cmd_ready), HW'(1));

        // Three sets of 64 rows, downstream always ready, then a held DONE.
        stall_pct = 0;
        build(2, 63, 1'b0);
        issue(2, 63);
        run_to_done(2, 63, "full");
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("done_hold", HW'({o_done, o_cmd_ready}), HW'(2'b10));
        end
        release_done();

        // Same shape with about a third of downstream cycles stalled.
        stall_pct = 33;
        build(2, 63, 1'b0);
        issue(2, 63);
        run_to_done(2, 63, "stall");
        release_done();

        // Smallest command: one set, one row, element 5 marked invalid.
        stall_pct = 0;
        build(0, 0, 1'b1);
        issue(0, 0);
        run_to_done(0, 0, "min");
        chk("pad_elem5", HW'(last_ifm_data[5*W_DATA +: W_DATA]), ZPAD ? HW'(0) : HW'(9'h0A5));
        release_done();

        // Abort at IFM beat 10 of set 1, then restart cleanly.
        build(2, 63, 1'b0);
        issue(2, 63);
        begin
            int n;
            n = 0;
            while (iout < N_ELEM + 10 && n < 4000) begin
                cycle();
                n++;
            end
        end
        chk("abort_point", HW'(iout), HW'(N_ELEM + 10));
        i_reset = 1'b0;
        #1;
        chk("abort_valids", HW'({o_wfm_valid, o_ifm_valid, o_done}), HW'(0));
        chk("abort_src_ready", HW'({o_src_wfm_ready, o_src_ifm_ready}), HW'(0));
        chk("abort_flags", HW'({o_wfm_is_last, o_ifm_inter_end, o_ifm_accum_end}), HW'(0));
        wsrc_q.delete();
        isrc_q.delete();
        wexp_q.delete();
        iexp_q.delete();
        wh = 1'b0;
        ih = 1'b0;
        #3;
        i_reset = 1'b1;
        stall_pct = 33;
        build(1, 2, 1'b0);
        issue(1, 2);
        run_to_done(1, 2, "restart");
        release_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
